stream_arbiter: RTL

- Packet-level round-robin arbiter sharing one resizer datapath between N_SRC independent input streams.
- Sits in front of the resizer's slave port; output handshake/keep/last/data semantics match the resizer's stream interface.
- Grant is locked for a whole packet (until the beat with last) so packets never interleave.
- One registered output stage.

---
 rtl/stream_arbiter_if.sv | 44 ++++
 rtl/stream_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter_if.sv
// Per-source request streams plus the single arbitrated output stream toward the resizer.
// m_trunc_o exists only when STREAM_ARBITER_MAXLEN_EN is defined.
// master = arbiter side, slave = sources/resizer side.
interface stream_arbiter_if #(
    parameter int N_SRC        = 2,
    parameter int S_KEEP_WIDTH = 3,
    parameter int T_DATA_WIDTH = 1
);
    localparam int SRC_W = $clog2(N_SRC);

    logic [N_SRC-1:0]                           s_valid_i;
    logic [N_SRC-1:0]                           s_ready_o;
    logic [N_SRC-1:0]                           s_last_i;
    logic [N_SRC*S_KEEP_WIDTH-1:0]              s_keep_i;
    logic [N_SRC*S_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_data_i;

    logic                                       m_valid_o;
    logic                                       m_ready_i;
    logic                                       m_last_o;
    logic [S_KEEP_WIDTH-1:0]                    m_keep_o;
    logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0]       m_data_o;
    logic [SRC_W-1:0]                           m_src_o;
`ifdef STREAM_ARBITER_MAXLEN_EN
    logic                                       m_trunc_o;

    modport master (
        input  s_valid_i, s_last_i, s_keep_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_last_o, m_keep_o, m_data_o, m_src_o, m_trunc_o
    );
    modport slave (
        output s_valid_i, s_last_i, s_keep_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_last_o, m_keep_o, m_data_o, m_src_o, m_trunc_o
    );
`else
    modport master (
        input  s_valid_i, s_last_i, s_keep_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_last_o, m_keep_o, m_data_o, m_src_o
    );
    modport slave (
        output s_valid_i, s_last_i, s_keep_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_last_o, m_keep_o, m_data_o, m_src_o
    );
`endif
endinterface

// File: rtl/stream_arbiter.sv
// Packet-level round-robin arbiter in front of the resizer; STREAM_ARBITER_MAXLEN_EN adds length truncation.
// Latency: 1 clk from source acceptance to m_valid_o; one idle bubble per packet for arbitration.
// Backpressure: granted source sees ready only when the output register is empty or draining.
module stream_arbiter #(
    parameter int N_SRC        = 2,
    parameter int S_KEEP_WIDTH = 3,
    parameter int T_DATA_WIDTH = 1
`ifdef STREAM_ARBITER_MAXLEN_EN
    ,
    parameter int MAX_BEATS    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    stream_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(N_SRC);
    localparam int DW    = S_KEEP_WIDTH * T_DATA_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q,   state_d;
    logic [SRC_W-1:0]        gnt_q,     gnt_d;
    logic [SRC_W-1:0]        rr_ptr_q,  rr_ptr_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q,  m_last_d;
    logic [S_KEEP_WIDTH-1:0] m_keep_q,  m_keep_d;
    logic [DW-1:0]           m_data_q,  m_data_d;
    logic [SRC_W-1:0]        m_src_q,   m_src_d;

    logic                    pick_vld;
    logic [SRC_W-1:0]        pick_idx;
    logic                    out_free;
    logic                    accept;
    logic                    release_gnt;
    logic                    sel_last;
    logic                    trunc_hit;
    logic [N_SRC-1:0]        s_ready;
    logic [S_KEEP_WIDTH-1:0] keep_arr [N_SRC];
    logic [DW-1:0]           data_arr [N_SRC];

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
        return SRC_W'((int'(base) + off) % N_SRC);
    endfunction

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            keep_arr[i] = bus.s_keep_i[i*S_KEEP_WIDTH +: S_KEEP_WIDTH];
            data_arr[i] = bus.s_data_i[i*DW +: DW];
        end
    end

    // Scan from farthest to nearest so the source closest after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (bus.s_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    assign out_free = !m_valid_q || bus.m_ready_i;
    assign sel_last = bus.s_last_i[gnt_q];
    assign accept   = (state_q == BUSY) && bus.s_valid_i[gnt_q] && out_free;

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            s_ready[i] = (state_q == BUSY) && (gnt_q == SRC_W'(i)) && out_free;
        end
    end

`ifdef STREAM_ARBITER_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             m_trunc_q,  m_trunc_d;

    assign trunc_hit = accept && !sel_last && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        m_trunc_d  = m_trunc_q;
        if (state_q == IDLE && pick_vld) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (accept) begin
            m_trunc_d = trunc_hit;
        end else if (bus.m_ready_i) begin
            m_trunc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            m_trunc_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            m_trunc_q  <= m_trunc_d;
        end
    end

    assign bus.m_trunc_o = m_trunc_q;
`else
    assign trunc_hit = 1'b0;
`endif

    assign release_gnt = accept && (sel_last || trunc_hit);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_keep_d  = m_keep_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_gnt) begin
                    rr_ptr_d = gnt_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat overwrites a draining one so packets stream at one beat per cycle.
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last || trunc_hit;
            m_keep_d  = keep_arr[gnt_q];
            m_data_d  = data_arr[gnt_q];
            m_src_d   = gnt_q;
        end else if (bus.m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= SRC_W'(N_SRC - 1);
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_keep_q  <= '0;
            m_data_q  <= '0;
            m_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_keep_q  <= m_keep_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_keep_o  = m_keep_q;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_src_o   = m_src_q;
endmodule
